// File: rtl/lut_cluster_config_loader_pkg.sv
// Shared types and constants for the LUT cluster configuration loader:
// command encodings, FSM states, header field positions and byte helpers.
package lut_cfg_loader_pkg;

    localparam logic [1:0] CMD_WRITE  = 2'b00;
    localparam logic [1:0] CMD_COMMIT = 2'b01;
    localparam logic [1:0] CMD_READ   = 2'b10;
    localparam logic [1:0] CMD_CLEAR  = 2'b11;

    localparam int HDR_CMD_LSB  = 6;
    localparam int HDR_AUTO_BIT = 5;
    localparam int HDR_RSV_LSB  = 3;
    localparam int HDR_IDX_LSB  = 0;

    localparam int BYTES_PER_LUT = 3;
    localparam int WORD_W        = 8 * BYTES_PER_LUT;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR0  = 3'd1,
        WR1  = 3'd2,
        WR2  = 3'd3,
        RD0  = 3'd4,
        RD1  = 3'd5,
        RD2  = 3'd6
    } state_e;

    function automatic logic [7:0] get_byte(input logic [WORD_W-1:0] word, input logic [1:0] sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/lut_cluster_config_loader_if.sv
// Byte-stream command input and read-back output of the configuration loader.
interface lut_cluster_config_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;

    modport slave  (input in_data, input in_valid, output in_ready,
                    output rd_data, output rd_valid, input rd_ready);
    modport master (output in_data, output in_valid, input in_ready,
                    input rd_data, input rd_valid, output rd_ready);
endinterface

// File: rtl/lut_cluster_config_loader_slot.sv
// One LUT's shadow and active configuration registers; active only ever
// changes as a whole word, so a LUT never sees a partially written value.
module lut_cfg_slot #(
    parameter int NoConfigBits = 19
) (
    input  logic                    UserCLK,
    input  logic                    resetn,
    input  logic                    wr_en,
    input  logic                    wr_commit,
    input  logic                    commit,
    input  logic                    clear,
    input  logic [NoConfigBits-1:0] wr_data,
    output logic [NoConfigBits-1:0] active
);
    logic [NoConfigBits-1:0] shadow_q, shadow_d;
    logic [NoConfigBits-1:0] active_q, active_d;

    // Next-state: clear dominates; an auto-committed write bypasses the shadow.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        if (clear) begin
            shadow_d = '0;
            active_d = '0;
        end else if (wr_en) begin
            shadow_d = wr_data;
            if (wr_commit) begin
                active_d = wr_data;
            end else begin
                active_d = active_q;
            end
        end else if (commit) begin
            active_d = shadow_q;
        end else begin
            active_d = active_q;
        end
    end

    // Configuration storage.
    always_ff @(posedge UserCLK) begin
        if (!resetn) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign active = active_q;
endmodule

// File: rtl/lut_cluster_config_loader.sv
// Header/data byte parser driving a cluster of LUT config slots, with
// shadow writes, atomic commit, byte-wise read-back and whole-cluster clear.
module lut_cluster_config_loader
    import lut_cfg_loader_pkg::*;
#(
    parameter int N_LUTS       = 8,
    parameter int NoConfigBits = 19
) (
    input  logic                           UserCLK,
    input  logic                           resetn,
    lut_cluster_config_loader_if.slave     bus,
    output logic [N_LUTS*NoConfigBits-1:0] ConfigBits,
    output logic                           busy,
    output logic                           err
);
    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic        auto_q, auto_d;
    logic [7:0]  b0_q, b0_d, b1_q, b1_d;
    logic        err_q, err_d;
    logic        in_ready_q, in_ready_d;
    logic        rd_valid_q, rd_valid_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        busy_q, busy_d;

    logic              in_xfer_s, rd_xfer_s, hdr_bad_s;
    logic [1:0]        hdr_cmd_s, hdr_rsv_s;
    logic [2:0]        hdr_idx_s, rd_idx_s;
    logic [WORD_W-1:0] wr_word_s, rd_word_s;
    logic              wr_slot_s, wr_commit_s, commit_all_s, clear_all_s;
    logic [NoConfigBits-1:0] active_s [N_LUTS];

    assign in_xfer_s = bus.in_valid && in_ready_q;
    assign rd_xfer_s = rd_valid_q && bus.rd_ready;
    assign hdr_cmd_s = bus.in_data[HDR_CMD_LSB +: 2];
    assign hdr_rsv_s = bus.in_data[HDR_RSV_LSB +: 2];
    assign hdr_idx_s = bus.in_data[HDR_IDX_LSB +: 3];
    assign hdr_bad_s = (hdr_rsv_s != 2'b00) || (int'(hdr_idx_s) >= N_LUTS);
    assign wr_word_s = {bus.in_data, b1_q, b0_q};
    assign rd_idx_s  = (state_q == IDLE) ? hdr_idx_s : idx_q;

    // Read-back mux over the active registers, zero-extended to a full word.
    always_comb begin
        rd_word_s = '0;
        for (int k = 0; k < N_LUTS; k++) begin
            if (3'(k) == rd_idx_s) begin
                rd_word_s = WORD_W'(active_s[k]);
            end else begin
                rd_word_s = rd_word_s;
            end
        end
    end

    // Command FSM next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        auto_d       = auto_q;
        b0_d         = b0_q;
        b1_d         = b1_q;
        err_d        = err_q;
        rd_valid_d   = rd_valid_q;
        rd_data_d    = rd_data_q;
        wr_slot_s    = 1'b0;
        wr_commit_s  = 1'b0;
        commit_all_s = 1'b0;
        clear_all_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_xfer_s && hdr_bad_s) begin
                    err_d = 1'b1;
                end else if (in_xfer_s) begin
                    case (hdr_cmd_s)
                        CMD_WRITE: begin
                            state_d = WR0;
                            idx_d   = hdr_idx_s;
                            auto_d  = bus.in_data[HDR_AUTO_BIT];
                        end
                        CMD_COMMIT: commit_all_s = 1'b1;
                        CMD_READ: begin
                            state_d    = RD0;
                            idx_d      = hdr_idx_s;
                            rd_valid_d = 1'b1;
                            rd_data_d  = get_byte(rd_word_s, 2'd0);
                        end
                        CMD_CLEAR: begin
                            clear_all_s = 1'b1;
                            err_d       = 1'b0;
                        end
                        default: state_d = IDLE;
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            WR0: begin
                if (in_xfer_s) begin
                    b0_d    = bus.in_data;
                    state_d = WR1;
                end else begin
                    state_d = WR0;
                end
            end
            WR1: begin
                if (in_xfer_s) begin
                    b1_d    = bus.in_data;
                    state_d = WR2;
                end else begin
                    state_d = WR1;
                end
            end
            WR2: begin
                if (in_xfer_s) begin
                    wr_slot_s   = 1'b1;
                    wr_commit_s = auto_q;
                    state_d     = IDLE;
                    // Bits above the LUT width are flagged but the low bits still land.
                    if ((wr_word_s >> NoConfigBits) != '0) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                end else begin
                    state_d = WR2;
                end
            end
            RD0: begin
                if (rd_xfer_s) begin
                    rd_data_d = get_byte(rd_word_s, 2'd1);
                    state_d   = RD1;
                end else begin
                    state_d = RD0;
                end
            end
            RD1: begin
                if (rd_xfer_s) begin
                    rd_data_d = get_byte(rd_word_s, 2'd2);
                    state_d   = RD2;
                end else begin
                    state_d = RD1;
                end
            end
            RD2: begin
                if (rd_xfer_s) begin
                    rd_valid_d = 1'b0;
                    state_d    = IDLE;
                end else begin
                    state_d = RD2;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = !((state_d == RD0) || (state_d == RD1) || (state_d == RD2));
        busy_d     = (state_d != IDLE);
    end

    // FSM state and registered outputs.
    always_ff @(posedge UserCLK) begin
        if (!resetn) begin
            state_q    <= IDLE;
            idx_q      <= 3'd0;
            auto_q     <= 1'b0;
            b0_q       <= 8'h00;
            b1_q       <= 8'h00;
            err_q      <= 1'b0;
            in_ready_q <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'h00;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            auto_q     <= auto_d;
            b0_q       <= b0_d;
            b1_q       <= b1_d;
            err_q      <= err_d;
            in_ready_q <= in_ready_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            busy_q     <= busy_d;
        end
    end

    for (genvar k = 0; k < N_LUTS; k++) begin : g_slot
        lut_cfg_slot #(.NoConfigBits(NoConfigBits)) u_slot (
            .UserCLK   (UserCLK),
            .resetn    (resetn),
            .wr_en     (wr_slot_s && (idx_q == 3'(k))),
            .wr_commit (wr_commit_s),
            .commit    (commit_all_s),
            .clear     (clear_all_s),
            .wr_data   (wr_word_s[NoConfigBits-1:0]),
            .active    (active_s[k])
        );
        assign ConfigBits[k*NoConfigBits +: NoConfigBits] = active_s[k];
    end

    assign bus.in_ready = in_ready_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign busy         = busy_q;
    assign err          = err_q;
endmodule

// File: tb/tb_lut_cluster_config_loader.sv
// Directed self-checking bench for lut_cluster_config_loader (N_LUTS=8, 19-bit LUTs).
module tb_lut_cluster_config_loader;
    localparam int N_LUTS = 8;
    localparam int NCB    = 19;

    logic                    UserCLK = 1'b0;
    logic                    resetn;
    logic [N_LUTS*NCB-1:0]   ConfigBits;
    logic                    busy;
    logic                    err;
    int                      checks = 0;
    int                      errors = 0;

    lut_cluster_config_loader_if bus();

    lut_cluster_config_loader #(.N_LUTS(N_LUTS), .NoConfigBits(NCB)) dut (
        .UserCLK    (UserCLK),
        .resetn     (resetn),
        .bus        (bus),
        .ConfigBits (ConfigBits),
        .busy       (busy),
        .err        (err)
    );

    always #5 UserCLK = ~UserCLK;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NCB-1:0] slice(input int k);
        return ConfigBits[k*NCB +: NCB];
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge UserCLK);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        check_val("in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge UserCLK);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge UserCLK);
        end
        #1;
    endtask

    task automatic read_lut(input logic [7:0] hdr, input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
        logic [7:0] got [3];
        int n;
        n = 0;
        got[0] = 8'h00; got[1] = 8'h00; got[2] = 8'h00;
        send_byte(hdr);
        bus.rd_ready = 1'b1;
        for (int c = 0; c < 20 && n < 3; c++) begin
            @(negedge UserCLK);
            if (bus.rd_valid) begin
                got[n] = bus.rd_data;
                n++;
            end
        end
        @(posedge UserCLK);
        #1;
        bus.rd_ready = 1'b0;
        check_val("rd_count", 64'(n), 64'd3);
        check_val("rd_b0", 64'(got[0]), 64'(e0));
        check_val("rd_b1", 64'(got[1]), 64'(e1));
        check_val("rd_b2", 64'(got[2]), 64'(e2));
        check_val("rd_done_valid", 64'(bus.rd_valid), 64'd0);
    endtask

    initial begin
        logic       pat [5];
        logic [7:0] exp_b [5];
        pat   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_b = '{8'hFF, 8'hFF, 8'hFF, 8'h03, 8'h03};
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        bus.rd_ready = 1'b0;
        resetn       = 1'b0;
        idle_cycles(2);
        resetn = 1'b1;
        check_val("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check_val("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
        check_val("rst_rd_data", 64'(bus.rd_data), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_err", 64'(err), 64'd0);
        check_val("rst_cfg", 64'(ConfigBits == '0), 64'd1);

        // Write without commit, including a stall mid-sequence
        send_byte(8'h02);
        send_byte(8'hAA);
        idle_cycles(3);
        check_val("wr_stall_busy", 64'(busy), 64'd1);
        send_byte(8'h55);
        check_val("wr_mid_slice2", 64'(slice(2)), 64'd0);
        send_byte(8'h07);
        check_val("wr_nocommit_slice2", 64'(slice(2)), 64'd0);
        check_val("wr_done_busy", 64'(busy), 64'd0);
        send_byte(8'h40);
        check_val("commit_slice2", 64'(slice(2)), 64'h755AA);
        check_val("commit_busy", 64'(busy), 64'd0);

        // Auto-commit write to idx 5
        send_byte(8'h25);
        send_byte(8'hFF);
        send_byte(8'hFF);
        check_val("auto_mid_slice5", 64'(slice(5)), 64'd0);
        send_byte(8'h03);
        check_val("auto_slice5", 64'(slice(5)), 64'h3FFFF);
        check_val("auto_slice2", 64'(slice(2)), 64'h755AA);
        check_val("auto_slice0", 64'(slice(0)), 64'd0);
        check_val("auto_err", 64'(err), 64'd0);

        // Read idx 5 with rd_ready toggling
        send_byte(8'h85);
        check_val("rd_valid_first", 64'(bus.rd_valid), 64'd1);
        check_val("rd_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge UserCLK);
            bus.rd_ready = pat[i];
            check_val("rd_stall_data", 64'(bus.rd_data), 64'(exp_b[i]));
            check_val("rd_stall_valid", 64'(bus.rd_valid), 64'd1);
            check_val("rd_in_ready", 64'(bus.in_ready), 64'd0);
        end
        @(posedge UserCLK);
        #1;
        bus.rd_ready = 1'b0;
        check_val("rd_end_valid", 64'(bus.rd_valid), 64'd0);
        check_val("rd_end_in_ready", 64'(bus.in_ready), 64'd1);
        check_val("rd_end_busy", 64'(busy), 64'd0);
        read_lut(8'h82, 8'hAA, 8'h55, 8'h07);

        // Reserved-bit header error
        send_byte(8'h0A);
        check_val("rsv_err", 64'(err), 64'd1);
        check_val("rsv_busy", 64'(busy), 64'd0);
        check_val("rsv_slice2", 64'(slice(2)), 64'h755AA);

        // Clear, then back-to-back write header
        send_byte(8'hC0);
        check_val("clr_err", 64'(err), 64'd0);
        check_val("clr_cfg", 64'(ConfigBits == '0), 64'd1);
        send_byte(8'h23);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h03);
        check_val("b2b_slice3", 64'(slice(3)), 64'h32211);
        send_byte(8'h40);
        check_val("clr_shadow2", 64'(slice(2)), 64'd0);

        // Oversized data: error flagged, low bits still written
        send_byte(8'h21);
        send_byte(8'h34);
        send_byte(8'h12);
        send_byte(8'hF8);
        check_val("ovf_err", 64'(err), 64'd1);
        check_val("ovf_slice1", 64'(slice(1)), 64'h01234);
        check_val("ovf_slice3", 64'(slice(3)), 64'h32211);
        send_byte(8'h04);
        send_byte(8'h78);
        send_byte(8'h56);
        send_byte(8'hFC);
        check_val("ovf_shadow_only", 64'(slice(4)), 64'd0);
        send_byte(8'h40);
        check_val("ovf_commit4", 64'(slice(4)), 64'h45678);

        // Reset in the middle of a write
        send_byte(8'h26);
        send_byte(8'h01);
        send_byte(8'h02);
        @(negedge UserCLK);
        resetn = 1'b0;
        @(posedge UserCLK);
        #1;
        resetn = 1'b1;
        check_val("mid_rst_cfg", 64'(ConfigBits == '0), 64'd1);
        check_val("mid_rst_err", 64'(err), 64'd0);
        check_val("mid_rst_busy", 64'(busy), 64'd0);
        send_byte(8'h26);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        check_val("post_rst_slice6", 64'(slice(6)), 64'h30201);
        send_byte(8'h50);
        check_val("rsv4_err", 64'(err), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
